// File: rtl/ram_bus_master.sv
// rtl/ram_bus_master.sv - APB-style RamBus initiator, one transfer outstanding; optional RAM_BUS_MASTER_TIMEOUT_EN access timeout
module ram_bus_master #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  CmdValid,
  output logic                  CmdReady,
  input  logic                  CmdWrnRd,
  input  logic [ADDR_WIDTH-1:0] CmdAddress,
  input  logic [DATA_WIDTH-1:0] CmdData,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic                  RspErr,
  output logic                  Busy,
  output logic                  RamBusnCs,
  output logic                  RamBusLatch,
  output logic                  RamBusWrnRd,
  output logic [ADDR_WIDTH-1:0] RamBusAddress,
  output logic [DATA_WIDTH-1:0] RamBusDataIn,
  input  logic [DATA_WIDTH-1:0] RamBusDataOut,
  input  logic                  RamBusAck
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;
  logic                  w_accept;
  logic                  w_ack;
  logic                  w_timeout;
  logic                  w_on_bus;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign w_accept = (r_state == ST_IDLE) && CmdValid;
  assign w_ack    = (r_state == ST_ACCESS) && RamBusAck;
  assign w_on_bus = (r_state == ST_SETUP) || (r_state == ST_ACCESS);

`ifdef RAM_BUS_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Count ACCESS cycles without Ack; cleared in SETUP so every transfer starts fresh
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !RamBusAck) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the last allowed Ack-less ACCESS cycle; an Ack in that cycle wins
  assign w_timeout = (r_state == ST_ACCESS) && !RamBusAck && (r_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    w_next        = r_state;
    CmdReady      = 1'b0;
    RspValid      = 1'b0;
    RspData       = '0;
    RspErr        = 1'b0;
    Busy          = (r_state != ST_IDLE);
    RamBusnCs     = w_on_bus;
    RamBusLatch   = (r_state == ST_ACCESS);
    RamBusWrnRd   = w_on_bus ? r_wr   : 1'b0;
    RamBusAddress = w_on_bus ? r_addr : '0;
    RamBusDataIn  = w_on_bus ? r_data : '0;
    case (r_state)
      ST_IDLE: begin
        CmdReady = 1'b1;
        if (CmdValid) w_next = ST_SETUP;
      end
      ST_SETUP: begin
        w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_ack || w_timeout) w_next = ST_RESP;
      end
      ST_RESP: begin
        RspValid = 1'b1;
        RspData  = r_rsp_data;
        RspErr   = r_rsp_err;
        if (RspReady) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Command latch and response capture
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_wr   <= CmdWrnRd;
      r_addr <= CmdAddress;
      r_data <= CmdData;
    end else if (w_ack) begin
      r_rsp_data <= r_wr ? '0 : RamBusDataOut;
      r_rsp_err  <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// tb/tb_ram_bus_master.sv - directed vector bench for ram_bus_master
module tb_ram_bus_master;

  logic        clk = 1'b0;
  logic        nRst;
  logic        CmdValid;
  logic        CmdReady;
  logic        CmdWrnRd;
  logic [13:0] CmdAddress;
  logic [31:0] CmdData;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspData;
  logic        RspErr;
  logic        Busy;
  logic        RamBusnCs;
  logic        RamBusLatch;
  logic        RamBusWrnRd;
  logic [13:0] RamBusAddress;
  logic [31:0] RamBusDataIn;
  logic [31:0] RamBusDataOut;
  logic        RamBusAck;

  int n_pass  = 0;
  int n_total = 0;

  ram_bus_master #(
    .ADDR_WIDTH    (14),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .nRst         (nRst),
    .CmdValid     (CmdValid),
    .CmdReady     (CmdReady),
    .CmdWrnRd     (CmdWrnRd),
    .CmdAddress   (CmdAddress),
    .CmdData      (CmdData),
    .RspValid     (RspValid),
    .RspReady     (RspReady),
    .RspData      (RspData),
    .RspErr       (RspErr),
    .Busy         (Busy),
    .RamBusnCs    (RamBusnCs),
    .RamBusLatch  (RamBusLatch),
    .RamBusWrnRd  (RamBusWrnRd),
    .RamBusAddress(RamBusAddress),
    .RamBusDataIn (RamBusDataIn),
    .RamBusDataOut(RamBusDataOut),
    .RamBusAck    (RamBusAck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        setup_ack;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present a command in IDLE and let the accepting edge pass; ends in SETUP
  task automatic start_cmd(input logic wr, input logic [13:0] addr, input logic [31:0] data);
    CmdValid   = 1'b1;
    CmdWrnRd   = wr;
    CmdAddress = addr;
    CmdData    = data;
    chk("idle_cmd_ready", CmdReady, 1'b1);
    step();
    CmdValid   = 1'b0;
    CmdWrnRd   = ~wr;
    CmdAddress = ~addr;
    CmdData    = ~data;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    start_cmd(v.wr, v.addr, v.wdata);
    RamBusAck     = v.setup_ack;
    RamBusDataOut = 32'hBAD0_BAD0;
    chk($sformatf("v%0d_setup_ncs", idx), RamBusnCs, 1'b1);
    chk($sformatf("v%0d_setup_latch", idx), RamBusLatch, 1'b0);
    chk($sformatf("v%0d_setup_addr", idx), RamBusAddress, v.addr);
    chk($sformatf("v%0d_setup_wr", idx), RamBusWrnRd, v.wr);
    chk($sformatf("v%0d_setup_cmd_ready", idx), CmdReady, 1'b0);
    chk($sformatf("v%0d_setup_busy", idx), Busy, 1'b1);
    if (v.wr) chk($sformatf("v%0d_setup_wdata", idx), RamBusDataIn, v.wdata);
    step();
    for (int w = 0; w <= v.waits; w++) begin
      RamBusAck     = (w == v.waits);
      RamBusDataOut = (w == v.waits) ? v.rdata : 32'hBAD0_BAD0;
      chk($sformatf("v%0d_acc%0d_ncs", idx, w), RamBusnCs, 1'b1);
      chk($sformatf("v%0d_acc%0d_latch", idx, w), RamBusLatch, 1'b1);
      chk($sformatf("v%0d_acc%0d_addr", idx, w), RamBusAddress, v.addr);
      chk($sformatf("v%0d_acc%0d_rsp_valid", idx, w), RspValid, 1'b0);
      step();
    end
    RamBusAck     = 1'b0;
    RamBusDataOut = 32'h5555_AAAA;
    chk($sformatf("v%0d_rsp_valid", idx), RspValid, 1'b1);
    chk($sformatf("v%0d_rsp_data", idx), RspData, v.exp_data);
    chk($sformatf("v%0d_rsp_err", idx), RspErr, 1'b0);
    chk($sformatf("v%0d_rsp_ncs", idx), RamBusnCs, 1'b0);
    chk($sformatf("v%0d_rsp_latch", idx), RamBusLatch, 1'b0);
    chk($sformatf("v%0d_rsp_addr", idx), RamBusAddress, 14'h0);
    step();
    chk($sformatf("v%0d_idle_rsp_valid", idx), RspValid, 1'b0);
    chk($sformatf("v%0d_idle_busy", idx), Busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 14'h0010, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 14'h3FFC, 32'h0,         3, 32'h1234_5678, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 14'h0000, 32'h0,         2, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5};
    vecs[3] = '{1'b1, 14'h3FFF, 32'hFFFF_FFFF, 1, 32'h1111_1111, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 14'h1234, 32'h0,         0, 32'h0000_0001, 1'b0, 32'h0000_0001};

    nRst          = 1'b0;
    CmdValid      = 1'b0;
    CmdWrnRd      = 1'b0;
    CmdAddress    = '0;
    CmdData       = '0;
    RspReady      = 1'b1;
    RamBusDataOut = '0;
    RamBusAck     = 1'b0;
    step();
    step();
    nRst = 1'b1;

    chk("rst_cmd_ready", CmdReady, 1'b1);
    chk("rst_rsp_valid", RspValid, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_ncs", RamBusnCs, 1'b0);
    chk("rst_latch", RamBusLatch, 1'b0);
    chk("rst_addr", RamBusAddress, 14'h0);
    chk("rst_rsp_data", RspData, 32'h0);
    chk("rst_rsp_err", RspErr, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Response backpressure with the next command waiting
    start_cmd(1'b0, 14'h0044, 32'h0);
    step();
    RamBusAck     = 1'b1;
    RamBusDataOut = 32'h0BAD_F00D;
    step();
    RamBusAck  = 1'b0;
    RspReady   = 1'b0;
    CmdValid   = 1'b1;
    CmdWrnRd   = 1'b1;
    CmdAddress = 14'h0123;
    CmdData    = 32'hCAFE_0001;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp%0d_rsp_valid", c), RspValid, 1'b1);
      chk($sformatf("bp%0d_cmd_ready", c), CmdReady, 1'b0);
      chk($sformatf("bp%0d_ncs", c), RamBusnCs, 1'b0);
      chk($sformatf("bp%0d_rsp_data", c), RspData, 32'h0BAD_F00D);
      step();
    end
    RspReady = 1'b1;
    step();
    chk("bp_idle_cmd_ready", CmdReady, 1'b1);
    chk("bp_idle_rsp_valid", RspValid, 1'b0);
    step();
    CmdValid = 1'b0;
    chk("bp_second_setup_ncs", RamBusnCs, 1'b1);
    chk("bp_second_setup_addr", RamBusAddress, 14'h0123);
    chk("bp_second_setup_wdata", RamBusDataIn, 32'hCAFE_0001);
    step();
    RamBusAck = 1'b1;
    step();
    RamBusAck = 1'b0;
    chk("bp_second_rsp_data", RspData, 32'h0);
    step();

    // Reset during ACCESS wait states
    start_cmd(1'b0, 14'h0200, 32'h0);
    step();
    step();
    chk("rstmid_latch_before", RamBusLatch, 1'b1);
    nRst = 1'b0;
    step();
    chk("rstmid_ncs", RamBusnCs, 1'b0);
    chk("rstmid_latch", RamBusLatch, 1'b0);
    chk("rstmid_rsp_valid", RspValid, 1'b0);
    nRst = 1'b1;
    chk("rstmid_cmd_ready", CmdReady, 1'b1);
    step();
    chk("rstmid_no_rsp", RspValid, 1'b0);
    chk("rstmid_idle_busy", Busy, 1'b0);

`ifdef RAM_BUS_MASTER_TIMEOUT_EN
    // Slave never acks: exactly four ACCESS cycles then an error response
    start_cmd(1'b0, 14'h0100, 32'h0);
    RamBusDataOut = 32'h7777_7777;
    step();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to_acc%0d_latch", c), RamBusLatch, 1'b1);
      step();
    end
    chk("to_rsp_valid", RspValid, 1'b1);
    chk("to_rsp_err", RspErr, 1'b1);
    chk("to_rsp_data", RspData, 32'h0);
    chk("to_ncs", RamBusnCs, 1'b0);
    step();
    chk("to_idle_rsp_valid", RspValid, 1'b0);
    run_vec(5, '{1'b0, 14'h0101, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D});
`else
    // Without the timeout, ACCESS waits indefinitely for Ack
    start_cmd(1'b0, 14'h0100, 32'h0);
    step();
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("nto_acc%0d_latch", c), RamBusLatch, 1'b1);
      chk($sformatf("nto_acc%0d_rsp_valid", c), RspValid, 1'b0);
      step();
    end
    RamBusAck     = 1'b1;
    RamBusDataOut = 32'hCAFE_F00D;
    step();
    RamBusAck = 1'b0;
    chk("nto_rsp_valid", RspValid, 1'b1);
    chk("nto_rsp_err", RspErr, 1'b0);
    chk("nto_rsp_data", RspData, 32'hCAFE_F00D);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
